// File: rtl/dcache_arbiter_if.sv
// Request/response bundle between the two cache requesters, the arbiter and the data cache.
// The slave modport is the arbiter's view; master is the requester/cache environment.
interface dcache_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] dc_addr;
  logic              dc_we;
  logic              dc_re;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dc_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output dc_addr, dc_we, dc_re, dc_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dc_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  dc_addr, dc_we, dc_re, dc_wdata
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Single-port data cache arbiter: round-robin between CPU and DMA, with a bounded
// DMA lock burst, one access per cycle and registered read data with a valid pulse.
module dcache_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dcache_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB,
    BURST
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
  logic              last_dma;
  logic              gnt_cpu, gnt_dma;
  logic              rr_cpu, rr_dma;
  logic              hold;
  logic              cpu_rvalid, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    gnt_cpu   = 1'b0;
    gnt_dma   = 1'b0;
    rr_cpu    = bus.cpu_req & (~bus.dma_req | last_dma);
    rr_dma    = bus.dma_req & ~rr_cpu;
    hold      = (state == BURST) & bus.dma_req & bus.dma_lock &
                (burst_cnt < CNT_W'(MAX_BURST));
    if (hold) begin
      gnt_dma = 1'b1;
      cnt_nxt = burst_cnt + CNT_W'(1);
    end else begin
      // A failed burst continuation falls back to round robin in the same cycle.
      gnt_cpu = rr_cpu;
      gnt_dma = rr_dma;
      if ((state == ARB) && rr_dma && bus.dma_lock && (MAX_BURST > 1)) begin
        state_nxt = BURST;
        cnt_nxt   = CNT_W'(1);
      end else begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      burst_cnt  <= '0;
      last_dma   <= 1'b1;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= cnt_nxt;
      if (gnt_cpu | gnt_dma)
        last_dma <= gnt_dma;
      cpu_rvalid <= gnt_cpu & ~bus.cpu_we;
      dma_rvalid <= gnt_dma & ~bus.dma_we;
      if (gnt_cpu & ~bus.cpu_we)
        cpu_rdata <= bus.dc_rdata;
      if (gnt_dma & ~bus.dma_we)
        dma_rdata <= bus.dc_rdata;
    end
  end

  assign bus.cpu_gnt    = gnt_cpu;
  assign bus.dma_gnt    = gnt_dma;
  assign bus.cpu_stall  = bus.cpu_req & ~gnt_cpu;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.dma_rdata  = dma_rdata;

  assign bus.dc_we    = (gnt_cpu & bus.cpu_we) | (gnt_dma & bus.dma_we);
  assign bus.dc_re    = (gnt_cpu & ~bus.cpu_we) | (gnt_dma & ~bus.dma_we);
  assign bus.dc_addr  = gnt_cpu ? bus.cpu_addr  : (gnt_dma ? bus.dma_addr  : '0);
  assign bus.dc_wdata = gnt_cpu ? bus.cpu_wdata : (gnt_dma ? bus.dma_wdata : '0);
endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic, all compared against
// a behavioural model of grants, cache contents and read responses.
module tb_dcache_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dcache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Cache environment: combinational read, write applied just after the clock edge.
  logic [DW-1:0] mem [32];
  assign bus.dc_rdata = mem[bus.dc_addr];

  // Reference model state.
  logic [DW-1:0] ref_mem [32];
  bit            m_last_dma;
  int            m_run, m_run_nxt;
  bit            m_g_cpu, m_g_dma;
  bit            e_cpu_rv, e_dma_rv;
  logic [DW-1:0] e_cpu_rd, e_dma_rd;
  bit            w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  bit            obs_cpu_gnt, obs_dma_gnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_dma = 1'b1;
    m_run      = 0;
    e_cpu_rv   = 1'b0;
    e_dma_rv   = 1'b0;
    e_cpu_rd   = '0;
    e_dma_rd   = '0;
  endtask

  // m_run counts consecutive locked DMA grants of the current burst (0 = none).
  task automatic eval_model();
    bit cont;
    cont = (m_run > 0) && (m_run < MB) && bus.dma_req && bus.dma_lock;
    m_g_cpu = 1'b0;
    m_g_dma = 1'b0;
    if (cont) begin
      m_g_dma   = 1'b1;
      m_run_nxt = m_run + 1;
    end else begin
      if (bus.cpu_req && bus.dma_req) begin
        m_g_cpu = m_last_dma;
        m_g_dma = !m_last_dma;
      end else begin
        m_g_cpu = bus.cpu_req;
        m_g_dma = bus.dma_req;
      end
      m_run_nxt = (m_run == 0 && m_g_dma && bus.dma_lock && MB > 1) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit            ewe, ere;
    eval_model();
    ea  = m_g_cpu ? bus.cpu_addr  : (m_g_dma ? bus.dma_addr  : '0);
    ed  = m_g_cpu ? bus.cpu_wdata : (m_g_dma ? bus.dma_wdata : '0);
    ewe = (m_g_cpu && bus.cpu_we) || (m_g_dma && bus.dma_we);
    ere = (m_g_cpu && !bus.cpu_we) || (m_g_dma && !bus.dma_we);
    chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(m_g_cpu));
    chk("dma_gnt",    32'(bus.dma_gnt),    32'(m_g_dma));
    chk("cpu_stall",  32'(bus.cpu_stall),  32'(bus.cpu_req && !m_g_cpu));
    chk("dc_we",      32'(bus.dc_we),      32'(ewe));
    chk("dc_re",      32'(bus.dc_re),      32'(ere));
    chk("dc_addr",    32'(bus.dc_addr),    32'(ea));
    chk("dc_wdata",   bus.dc_wdata,        ed);
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cpu_rv));
    chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(e_dma_rv));
    chk("cpu_rdata",  bus.cpu_rdata,       e_cpu_rd);
    chk("dma_rdata",  bus.dma_rdata,       e_dma_rd);
    w_en   = bus.dc_we;
    w_addr = bus.dc_addr;
    w_data = bus.dc_wdata;
    obs_cpu_gnt = bus.cpu_gnt;
    obs_dma_gnt = bus.dma_gnt;
  endtask

  task automatic commit();
    if (w_en) mem[w_addr] = w_data;
    e_cpu_rv = m_g_cpu && !bus.cpu_we;
    e_dma_rv = m_g_dma && !bus.dma_we;
    if (e_cpu_rv) e_cpu_rd = ref_mem[bus.cpu_addr];
    if (e_dma_rv) e_dma_rd = ref_mem[bus.dma_addr];
    if (m_g_cpu && bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
    if (m_g_dma && bus.dma_we) ref_mem[bus.dma_addr] = bus.dma_wdata;
    if (m_g_cpu || m_g_dma) m_last_dma = m_g_dma;
    m_run = m_run_nxt;
  endtask

  // Inputs are set by the caller just after a rising edge; returns just after the next one.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic set_cpu(input bit req, input bit we, input int addr, input logic [DW-1:0] data);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = AW'(addr);
    bus.cpu_wdata = data;
  endtask

  task automatic set_dma(input bit req, input bit we, input bit lock, input int addr,
                         input logic [DW-1:0] data);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_lock  = lock;
    bus.dma_addr  = AW'(addr);
    bus.dma_wdata = data;
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  initial begin
    logic [5:0] seq;
    logic [2:0] seq3;
    int         dcount;

    rst_n = 1'b0;
    set_cpu(0, 0, 0, '0);
    set_dma(0, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Store then load through the CPU port.
    set_cpu(1, 1, 3, 32'hDEADBEEF);
    cycle();
    set_cpu(1, 0, 3, '0);
    cycle();
    set_cpu(0, 0, 0, '0);
    chk("t1_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    chk("t1_rdata",  bus.cpu_rdata,       32'hDEADBEEF);
    cycle();

    // Both ports loading: round robin alternation.
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 0, 3, '0);
      set_dma(1, 0, 0, 10 + i, '0);
      cycle();
    end
    set_cpu(0, 0, 0, '0);
    set_dma(0, 0, 0, 0, '0);
    cycle();

    // Locked DMA write burst against a waiting CPU: CPU last, so DMA wins first.
    set_cpu(1, 0, 7, '0);
    cycle();
    seq    = '0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      set_cpu(1, 0, 7, '0);
      set_dma(1, 1, 1, dcount, $urandom);
      cycle();
      seq = {seq[4:0], obs_dma_gnt};
      if (m_g_dma) dcount++;
    end
    chk("t3_grant_seq", 32'(seq), 32'h3D);

    // Drain the burst, then lock released after two grants.
    set_cpu(0, 0, 0, '0);
    set_dma(0, 0, 0, 0, '0);
    cycle();
    set_cpu(1, 1, 20, $urandom);
    cycle();
    seq3 = '0;
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 0, 20, '0);
      set_dma(1, 0, (i < 2) ? 1'b1 : 1'b0, 21 + i, '0);
      cycle();
      seq3 = {seq3[1:0], obs_cpu_gnt};
    end
    chk("t4_grant_seq", 32'(seq3), 32'h1);
    set_cpu(1, 0, 20, '0);
    set_dma(1, 0, 1, 25, '0);
    cycle();
    set_cpu(0, 0, 0, '0);
    set_dma(0, 0, 0, 0, '0);
    cycle();

    // Idle cycles.
    for (int i = 0; i < 3; i++) cycle();

    // Reset asserted during a locked DMA read grant.
    set_dma(1, 0, 1, 4, '0);
    cycle();
    set_cpu(1, 0, 5, '0);
    @(negedge clk);
    check_all();
    #1;
    rst_n = 1'b0;
    set_cpu(0, 0, 0, '0);
    set_dma(0, 0, 0, 0, '0);
    #1;
    chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'h0);
    chk("rst_dma_gnt",    32'(bus.dma_gnt),    32'h0);
    chk("rst_dc_re",      32'(bus.dc_re),      32'h0);
    chk("rst_dc_addr",    32'(bus.dc_addr),    32'h0);
    chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
    chk("rst_dma_rdata",  bus.dma_rdata,       32'h0);
    chk("rst_cpu_rdata",  bus.cpu_rdata,       32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_dma_rvalid_after_edge", 32'(bus.dma_rvalid), 32'h0);
    rst_n = 1'b1;
    set_cpu(1, 0, 5, '0);
    set_dma(1, 0, 1, 6, '0);
    cycle();
    chk("rst_first_gnt_cpu", 32'(obs_cpu_gnt), 32'h1);

    // Randomized traffic in phases of differing contention and lock density.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        set_cpu(pct(ph == 0 ? 50 : 70), pct(40), int'($urandom_range(0, 31)), $urandom);
        set_dma(pct(ph == 2 ? 90 : 60), pct(50), pct(ph == 0 ? 30 : 85),
                int'($urandom_range(0, 31)), $urandom);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dcache_arbiter.md
Name: dcache_arbiter

Overview:
- Shares the single-port 32x32 data cache between two requesters: the pipeline MEM stage (cpu port) and the DMA/debug loader (dma port).
- Grants at most one access per cycle and drives the cache write/read enables, address and write data.
- Registers read data and returns it with a one-cycle valid pulse.
- A DMA lock mode gives bounded back-to-back burst ownership; the CPU stalls while it is denied.

Parameters:
ADDR_W, 5, cache word-address width (32 entries)
DATA_W, 32, data word width
MAX_BURST, 4, max consecutive locked DMA grants (>=1; 1 disables locking)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_gnt  out  1  CPU access performed this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU load data valid (1-cycle pulse)
cpu_rdata  out  DATA_W  CPU load data
dma_req  in  1  DMA access request, held until granted
dma_we  in  1  1=write, 0=read
dma_lock  in  1  request burst ownership
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access performed this cycle
dma_rvalid  out  1  DMA read data valid (1-cycle pulse)
dma_rdata  out  DATA_W  DMA read data
dc_addr  out  ADDR_W  to cache address
dc_we  out  1  to cache write enable
dc_re  out  1  to cache read enable
dc_wdata  out  DATA_W  to cache write data
dc_rdata  in  DATA_W  from cache, combinational read data

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset: state=ARB, last_gnt=DMA, burst_cnt=0, cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=0.
- Reset asserted mid-burst or with a response pending: that response is dropped and rvalid stays 0.
- Grants and dc_* outputs are combinational from state and requests. gnt=0 when no request.
- Cache port:
  - dc_we = granted & we; dc_re = granted & ~we.
  - dc_addr/dc_wdata are muxed from the winner.
  - With no grant, all dc_* outputs are 0.
  - A write completes at the grant clock edge.
- Read response:
  - On a granted read, dc_rdata is captured at the grant edge into the owner's rdata register.
  - The owner's rvalid is 1 in the following cycle only.
  - rdata holds until the owner's next read.
  - Writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back reads give consecutive rvalid pulses.
- State ARB:
  - Single request: granted.
  - Both requesting: grant the port that is not last_gnt (round robin).
  - last_gnt updates on every grant.
  - DMA granted with dma_lock=1: burst_cnt=1, next state BURST (if MAX_BURST>1). Otherwise burst_cnt=0.
- State BURST:
  - If dma_req & dma_lock & burst_cnt<MAX_BURST: grant DMA regardless of cpu_req, and burst_cnt++.
  - Otherwise: apply the ARB rule this same cycle, clear burst_cnt, next state ARB.
  - The grant that makes burst_cnt==MAX_BURST is the last locked grant. The next cycle uses the ARB rule with last_gnt=DMA, so a pending CPU wins.
- Address/data are sampled only in the grant cycle. Requester inputs may change freely when not granted.
- cpu_stall is asserted in every cycle cpu_req=1 and cpu_gnt=0.

Test Plan:
1. Reset, CPU store addr 3 data 0xDEADBEEF, then CPU load addr 3 -> cpu_gnt each cycle, dc_we=1 then dc_re=1, next cycle cpu_rvalid=1 with cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
2. cpu_req and dma_req (both loads) held 4 cycles after reset -> grants alternate CPU,DMA,CPU,DMA; cpu_stall=1 on DMA cycles; each rvalid one cycle after its grant.
3. MAX_BURST=4: DMA writes addrs 0..5 with dma_lock=1 while cpu_req=1 -> DMA granted 4 cycles, CPU granted 5th, DMA 6th; cpu_stall=1 for the first 4 cycles.
4. Burst where dma_lock drops after 2 grants with cpu_req=1 -> CPU granted the same cycle the lock drops; state returns to ARB.
5. rst_n pulsed low asynchronously mid-burst, the cycle after a DMA read grant -> all outputs 0 immediately, dma_rvalid never asserts, and the first grant after release goes to CPU on contention.
6. No requests for 3 cycles -> dc_we=dc_re=0, dc_addr=0, both gnt=0, rvalid=0.
